// File: rtl/vga_xfer_pkg.sv
// rtl/vga_xfer_pkg.sv - shared types, constants and helpers for the frame transfer path
package vga_xfer_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_READ = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_EMIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_READ = S_READ,
        ST_LOAD = S_LOAD,
        ST_EMIT = S_EMIT,
        ST_DONE = S_DONE
    } xfer_state_e;

    localparam logic LANE_LSB_FIRST = 1'b0;
    localparam logic LANE_MSB_FIRST = 1'b1;

    function automatic int calc_ppw(input int word_w, input int pixel_w);
        return word_w / pixel_w;
    endfunction

    // Index width that stays at least one bit for single-entry counters.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - combinational lane mux selecting one pixel out of a packed word
module pixel_unpacker
    import vga_xfer_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int PIXEL_W = 8,
    parameter int PPW     = calc_ppw(WORD_W, PIXEL_W),
    parameter int LANE_W  = idx_width(PPW)
) (
    input  logic [WORD_W-1:0]  word_i,
    input  logic [LANE_W-1:0]  lane_i,
    input  logic               lane_order_i,
    output logic [PIXEL_W-1:0] pixel_o
);

    logic [LANE_W-1:0] sel;

    always_comb begin
        sel     = lane_i;
        pixel_o = '0;
        if (lane_order_i == LANE_MSB_FIRST) begin
            sel = LANE_W'(PPW - 1) - lane_i;
        end
        for (int i = 0; i < PPW; i++) begin
            if (sel == LANE_W'(i)) begin
                pixel_o = word_i[i*PIXEL_W +: PIXEL_W];
            end
        end
    end

endmodule

// File: rtl/vga_frame_transfer.sv
// rtl/vga_frame_transfer.sv - frame copy from data memory into the VGA framebuffer
module vga_frame_transfer
    import vga_xfer_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int PIXEL_W     = 8,
    parameter int ADDR_W      = 17,
    parameter int FB_ADDR_W   = 17,
    parameter int FRAME_WORDS = 19200
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [ADDR_W-1:0]    src_base_i,
    input  logic                 lane_order_i,
    output logic                 src_rd_o,
    output logic [ADDR_W-1:0]    src_addr_o,
    input  logic [WORD_W-1:0]    src_rdata_i,
    input  logic                 fb_stall_i,
    output logic                 fb_we_o,
    output logic [FB_ADDR_W-1:0] fb_addr_o,
    output logic [PIXEL_W-1:0]   fb_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int PPW    = calc_ppw(WORD_W, PIXEL_W);
    localparam int LANE_W = idx_width(PPW);
    localparam int CNT_W  = idx_width(FRAME_WORDS);

    if ((WORD_W % PIXEL_W) != 0) begin : g_bad_pixel_w
        $error("PIXEL_W must divide WORD_W");
    end
    if ((longint'(FRAME_WORDS) * longint'(PPW)) > (64'd1 << FB_ADDR_W)) begin : g_bad_frame
        $error("frame does not fit in the framebuffer address space");
    end

    xfer_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 order_q, order_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [LANE_W-1:0]    lane_q, lane_d;
    logic [FB_ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic [WORD_W-1:0]    word_reg_q, word_reg_d;

    logic lane_last;
    logic word_last;

    assign lane_last = (lane_q == LANE_W'(PPW - 1));
    assign word_last = (word_cnt_q == CNT_W'(FRAME_WORDS - 1));

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        order_d    = order_q;
        word_cnt_d = word_cnt_q;
        lane_d     = lane_q;
        pix_addr_d = pix_addr_q;
        word_reg_d = word_reg_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d     = src_base_i;
                    order_d    = lane_order_i;
                    word_cnt_d = '0;
                    lane_d     = '0;
                    pix_addr_d = '0;
                    state_d    = ST_READ;
                end
            end
            ST_READ: state_d = ST_LOAD;
            ST_LOAD: begin
                word_reg_d = src_rdata_i;
                state_d    = ST_EMIT;
            end
            ST_EMIT: begin
                if (!fb_stall_i) begin
                    pix_addr_d = pix_addr_q + FB_ADDR_W'(1);
                    if (lane_last) begin
                        lane_d = '0;
                        if (word_last) begin
                            state_d = ST_DONE;
                        end else begin
                            word_cnt_d = word_cnt_q + CNT_W'(1);
                            state_d    = ST_READ;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides every other transition but cannot cancel a start from IDLE.
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            order_q    <= 1'b0;
            word_cnt_q <= '0;
            lane_q     <= '0;
            pix_addr_q <= '0;
            word_reg_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            order_q    <= order_d;
            word_cnt_q <= word_cnt_d;
            lane_q     <= lane_d;
            pix_addr_q <= pix_addr_d;
            word_reg_q <= word_reg_d;
        end
    end

    pixel_unpacker #(
        .WORD_W  (WORD_W),
        .PIXEL_W (PIXEL_W),
        .PPW     (PPW),
        .LANE_W  (LANE_W)
    ) u_unpacker (
        .word_i       (word_reg_q),
        .lane_i       (lane_q),
        .lane_order_i (order_q),
        .pixel_o      (fb_data_o)
    );

    // Address wraps modulo 2^ADDR_W by plain truncation.
    assign src_rd_o   = (state_q == ST_READ);
    assign src_addr_o = base_q + ADDR_W'(word_cnt_q);
    assign fb_we_o    = (state_q == ST_EMIT) && !fb_stall_i;
    assign fb_addr_o  = pix_addr_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = (state_q == ST_DONE);

endmodule

// File: tb/tb_vga_frame_transfer.sv
// tb/tb_vga_frame_transfer.sv - scoreboard bench for vga_frame_transfer with a cycle-timeline model
module tb_vga_frame_transfer;

    localparam int FW  = 3;
    localparam int WW  = 32;
    localparam int PW  = 8;
    localparam int AW  = 17;
    localparam int FAW = 17;
    localparam int PPW = WW / PW;

    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
    } rd_t;

    typedef struct {
        int             cyc;
        logic [FAW-1:0] addr;
        logic [PW-1:0]  data;
    } wr_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [AW-1:0]  src_base = '0;
    logic           lane_order = 1'b0;
    logic           src_rd;
    logic [AW-1:0]  src_addr;
    logic [WW-1:0]  src_rdata = '0;
    logic           fb_stall = 1'b0;
    logic           fb_we;
    logic [FAW-1:0] fb_addr;
    logic [PW-1:0]  fb_data;
    logic           busy;
    logic           done;

    vga_frame_transfer #(
        .WORD_W      (WW),
        .PIXEL_W     (PW),
        .ADDR_W      (AW),
        .FB_ADDR_W   (FAW),
        .FRAME_WORDS (FW)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .abort_i      (abort),
        .src_base_i   (src_base),
        .lane_order_i (lane_order),
        .src_rd_o     (src_rd),
        .src_addr_o   (src_addr),
        .src_rdata_i  (src_rdata),
        .fb_stall_i   (fb_stall),
        .fb_we_o      (fb_we),
        .fb_addr_o    (fb_addr),
        .fb_data_o    (fb_data),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [WW-1:0] mem [int];
    always @(posedge clock) begin
        if (src_rd) src_rdata <= mem.exists(int'(src_addr)) ? mem[int'(src_addr)] : '0;
    end

    bit  sched [0:8191];
    rd_t rq[$];
    wr_t wq[$];
    int  dq[$];

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_done = 0;
    int last_done = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Timeline model: READ, LOAD, then one write per unstalled EMIT cycle; events after cutoff are dropped.
    task automatic model_frame(input int s, input logic [AW-1:0] base, input logic order,
                               input int cutoff, output int end_t);
        int            t;
        int            pix;
        int            ln;
        logic [AW-1:0] a;
        logic [WW-1:0] w;
        t   = s + 1;
        pix = 0;
        for (int k = 0; k < FW; k++) begin
            a = base + AW'(k);
            if (t <= cutoff) rq.push_back('{t, a});
            w = mem.exists(int'(a)) ? mem[int'(a)] : '0;
            t += 2;
            for (int l = 0; l < PPW; l++) begin
                while (sched[t]) t++;
                ln = order ? (PPW - 1 - l) : l;
                if (t <= cutoff) wq.push_back('{t, FAW'(pix), PW'((w >> (PW * ln)) & 32'hFF)});
                pix++;
                t++;
            end
        end
        if (t <= cutoff) dq.push_back(t);
        end_t = (t < cutoff) ? t : cutoff;
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_reads_left"}, rq.size(), 0);
        chk({tag, "_writes_left"}, wq.size(), 0);
        chk({tag, "_done_left"}, dq.size(), 0);
        rq.delete();
        wq.delete();
        dq.delete();
    endtask

    task automatic run_frame(input string tag, input logic [AW-1:0] base, input logic order,
                             input int prob, input int st_from, input int st_len,
                             input int abort_rel, input int pulse_rel, output int s);
        int c;
        int end_t;
        int cutoff;
        @(posedge clock);
        #1;
        s = cyc;
        for (int i = s; i < s + 256; i++) begin
            sched[i] = ($urandom_range(99) < prob) || (i >= s + st_from && i < s + st_from + st_len);
        end
        cutoff = (abort_rel >= 0) ? s + abort_rel : 32'h3FFF_FFFF;
        model_frame(s, base, order, cutoff, end_t);
        n_writes   = 0;
        n_done     = 0;
        last_done  = -1;
        start      = 1'b1;
        src_base   = base;
        lane_order = order;
        abort      = 1'b0;
        fb_stall   = sched[s];
        do begin
            @(posedge clock);
            #1;
            c        = cyc;
            start    = (c == s + pulse_rel);
            abort    = (c == s + abort_rel);
            fb_stall = sched[c];
        end while (c <= end_t + 1);
        start    = 1'b0;
        abort    = 1'b0;
        fb_stall = 1'b0;
        chk({tag, "_busy_after"}, busy, 1'b0);
        check_drained(tag);
    endtask

    task automatic fill_words(input logic [AW-1:0] base, input logic [WW-1:0] w0,
                              input logic [WW-1:0] w1, input logic [WW-1:0] w2);
        mem[int'(base)]          = w0;
        mem[int'(base + AW'(1))] = w1;
        mem[int'(base + AW'(2))] = w2;
    endtask

    initial begin : monitor
        rd_t r;
        wr_t w;
        int  d;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (src_rd === 1'b1) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_read: got addr %0h at cycle %0d expected none", src_addr, cyc);
                    end else begin
                        r = rq.pop_front();
                        chk("rd_cycle", cyc, r.cyc);
                        chk("rd_addr", src_addr, r.addr);
                    end
                end
                if (fb_we === 1'b1) begin
                    n_writes++;
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h at cycle %0d expected none", fb_addr, cyc);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_cycle", cyc, w.cyc);
                        chk("wr_addr", fb_addr, w.addr);
                        chk("wr_data", fb_data, w.data);
                    end
                end
                if (done === 1'b1) begin
                    n_done++;
                    last_done = cyc;
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
                    end else begin
                        d = dq.pop_front();
                        chk("done_cycle", cyc, d);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_src_rd"}, src_rd, 0);
        chk({tag, "_src_addr"}, src_addr, 0);
        chk({tag, "_fb_we"}, fb_we, 0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_data"}, fb_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int s;
        int c;
        int end_t;
        logic [AW-1:0] b;
        int ar;

        #12;
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        fill_words(17'h00010, 32'h44332211, 32'h88776655, 32'hCCBBAA99);
        run_frame("basic", 17'h00010, 1'b0, 0, -1, 0, -1, -1, s);
        chk("basic_done_rel", last_done - s, 19);
        chk("basic_writes", n_writes, 12);

        run_frame("lane_msb", 17'h00010, 1'b1, 0, -1, 0, -1, -1, s);
        chk("lane_msb_writes", n_writes, 12);

        run_frame("stall", 17'h00010, 1'b0, 0, 10, 5, -1, -1, s);
        chk("stall_done_rel", last_done - s, 24);

        fill_words(17'h1FFFF, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF);
        run_frame("wrap", 17'h1FFFF, 1'b0, 0, -1, 0, -1, -1, s);

        run_frame("abort", 17'h00010, 1'b0, 0, -1, 0, 8, -1, s);
        chk("abort_no_done", n_done, 0);
        run_frame("after_abort", 17'h00010, 1'b0, 0, -1, 0, -1, -1, s);
        chk("after_abort_done", n_done, 1);

        run_frame("start_busy", 17'h00010, 1'b0, 0, -1, 0, -1, 5, s);
        chk("start_busy_writes", n_writes, 12);
        chk("start_busy_dones", n_done, 1);

        // Asynchronous reset in the middle of the second pixel of word 0.
        @(posedge clock);
        #1;
        s = cyc;
        for (int i = s; i < s + 256; i++) sched[i] = 1'b0;
        model_frame(s, 17'h00010, 1'b0, s + 3, end_t);
        n_writes   = 0;
        start      = 1'b1;
        src_base   = 17'h00010;
        lane_order = 1'b0;
        do begin
            @(posedge clock);
            #1;
            c     = cyc;
            start = 1'b0;
        end while (c < s + 4);
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("async_reset_writes", n_writes, 1);
        check_drained("async_reset");
        run_frame("after_reset", 17'h00010, 1'b1, 0, -1, 0, -1, -1, s);

        for (int k = 0; k < 8; k++) begin
            b = AW'($urandom);
            fill_words(b, $urandom, $urandom, $urandom);
            ar = ($urandom_range(2) == 0) ? int'($urandom_range(18, 1)) : -1;
            run_frame("random", b, 1'($urandom_range(1)), 30, -1, 0, ar, int'($urandom_range(15, 2)), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_frame_transfer.md
# vga_frame_transfer

Parametrised successor to the single-counter memory-to-VGA transfer path. On a start command it reads a full frame of packed words from data memory, unpacks each word into PIXEL_W-bit pixels in a selectable lane order, and writes them sequentially into the VGA framebuffer. It sits between the data-memory read port and the VGA adapter write port. It provides a proper FSM, abort, back-pressure and a completion pulse.

## Interface
Parameters:
- WORD_W, 32, data-memory word width
- PIXEL_W, 8, framebuffer pixel width; must divide WORD_W (PPW = WORD_W/PIXEL_W pixels per word)
- ADDR_W, 17, data-memory address width
- FB_ADDR_W, 17, framebuffer address width
- FRAME_WORDS, 19200, words per frame (320x240 at 8 bpp); FRAME_WORDS*PPW <= 2^FB_ADDR_W, checked at elaboration

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  begin a frame transfer (honoured only in IDLE)
- abort  in  1  terminate the transfer, return to IDLE
- src_base  in  ADDR_W  first data-memory word address, sampled with start
- lane_order  in  1  0: bits [PIXEL_W-1:0] first; 1: MSB lane first; sampled with start
- src_rd  out  1  data-memory read strobe
- src_addr  out  ADDR_W  data-memory read address
- src_rdata  in  WORD_W  read data, valid the cycle after src_rd
- fb_stall  in  1  framebuffer back-pressure; holds pixel emission
- fb_we  out  1  framebuffer write enable
- fb_addr  out  FB_ADDR_W  framebuffer pixel address
- fb_data  out  PIXEL_W  pixel value
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a completed frame

## Operation
- States: IDLE, READ, LOAD, EMIT, DONE.
- IDLE: start=1 latches src_base and lane_order and clears word_cnt, lane and pix_addr. The next state is READ.
- READ: src_rd=1 and src_addr=base+word_cnt, modulo 2^ADDR_W (wrap, no error). The next state is LOAD.
- LOAD: src_rdata is registered into word_reg. The next state is EMIT.
- EMIT: fb_we=!fb_stall, fb_data=lane[lane] of word_reg, fb_addr=pix_addr.
  - When not stalled, lane and pix_addr advance.
  - After lane PPW-1 is written, the FSM goes to DONE if word_cnt==FRAME_WORDS-1. Otherwise word_cnt increments and the FSM goes to READ.
- fb_stall=1 in EMIT: fb_we=0, and lane, pix_addr and state hold. fb_stall is ignored in all other states.
- DONE: done=1 for one cycle, then IDLE.
- abort=1 in any non-IDLE state: next state IDLE. No done, no further src_rd or fb_we.
  - abort has priority over all other transitions.
  - abort in IDLE is ignored.
- start outside IDLE is ignored. start and abort together in IDLE: start wins, because abort is ignored in IDLE.
- pix_addr is a dedicated counter, not a multiplier. It reaches FRAME_WORDS*PPW-1 on the final write.

## Timing
- Reset values:
  - State: IDLE
  - Outputs: src_rd=0, src_addr=0, fb_we=0, fb_addr=0, fb_data=0, busy=0, done=0
  - Internal: word_reg and all counters 0
- All outputs are Moore, decoded from registered state and counters. The only exception is fb_we, which is gated combinationally by fb_stall.
- Start sampled at cycle 0 gives READ in cycle 1, LOAD in cycle 2, and the first fb_we in cycle 3.
- Each word takes PPW+2 cycles without stall. Each stalled cycle adds one cycle.
- Without stall, done is asserted in cycle FRAME_WORDS*(PPW+2)+1. busy falls the cycle after done.
- Reset asserted mid-transfer forces IDLE and reset values immediately, without waiting for a clock edge.

## Structure
- Package vga_xfer_pkg holds:
  - the state enum (IDLE, READ, LOAD, EMIT, DONE)
  - the LANE_LSB_FIRST/LANE_MSB_FIRST constants
  - the PPW derivation function
- Sub-module pixel_unpacker: a combinational lane mux (word, lane index, lane_order to pixel), parametrised by WORD_W/PIXEL_W.
- The top contains the FSM, counters and registers.

## Test plan
All scenarios use FRAME_WORDS=3 and the default widths (PPW=4) unless stated otherwise.
- Basic frame: src_base=0x00010, lane_order=0, memory holds words 0x44332211, 0x88776655, 0xCCBBAA99.
  - src_rd at addresses 0x10, 0x11, 0x12.
  - fb writes 0x11, 0x22 … 0xCC at fb_addr 0..11.
  - done in cycle 19.
- Lane order: same data with lane_order=1. First four writes are 0x44, 0x33, 0x22, 0x11 at fb_addr 0..3.
- Stall: fb_stall=1 for 5 cycles during the second pixel of word 1. Data and addresses are unchanged and done moves to cycle 24.
- Address wrap: src_base=0x1FFFF. src_addr sequence is 0x1FFFF, 0x00000, 0x00001.
- Abort: abort in the LOAD state of word 1.
  - IDLE next cycle, busy=0, no done, no further fb_we.
  - A following start runs a full correct frame.
- Reset and start filtering:
  - start pulsed while busy is ignored: exactly 12 writes and one done.
  - Async reset asserted mid-EMIT clears all outputs to their reset values without waiting for a clock edge.
